// File: rtl/rf_alu_sequencer.sv
// Control-side sequencer for the register-file/ALU datapath: accepts one encoded
// operation per handshake, drives RF addresses, write strobe and ALU opcode, returns the result.
module rf_alu_sequencer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8,
    localparam int INSTR_W = 2 + 3*ADDR_W + 1 + CNT_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               instr_valid_i,
    output logic               instr_ready_o,
    output logic [ADDR_W-1:0]  rf_A1_o,
    output logic [ADDR_W-1:0]  rf_A2_o,
    output logic [ADDR_W-1:0]  rf_A3_o,
    output logic               rf_we_o,
    output logic [1:0]         alu_opcode_o,
    input  logic [DATA_W-1:0]  alu_result_i,
    output logic [DATA_W-1:0]  result_o,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic               busy_o
);

    localparam int RD_LSB  = 2;
    localparam int RS1_LSB = 2 + ADDR_W;
    localparam int RS2_LSB = 2 + 2*ADDR_W;
    localparam int WB_BIT  = 2 + 3*ADDR_W;
    localparam int CNT_LSB = 3 + 3*ADDR_W;

    // One-hot so every control output is a single flop bit, free of decode glitches.
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        ISSUE = 4'b0010,
        WRITE = 4'b0100,
        DONE  = 4'b1000
    } state_e;

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0]   iter_q, iter_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               wb;
    logic [CNT_W-1:0]   cnt;

    assign wb  = instr_q[WB_BIT];
    assign cnt = instr_q[CNT_LSB +: CNT_W];

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        iter_d   = iter_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (instr_valid_i) begin
                    instr_d = instr_i;
                    iter_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (wb) begin
                    state_d = WRITE;
                end else begin
                    result_d = alu_result_i;
                    state_d  = DONE;
                end
            end
            WRITE: begin
                // Equality compare keeps cnt=max from wrapping the counter.
                result_d = alu_result_i;
                if (iter_q != cnt) begin
                    iter_d  = iter_q + CNT_W'(1);
                    state_d = ISSUE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            iter_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            iter_q   <= iter_d;
            result_q <= result_d;
        end
    end

    assign rf_A1_o        = instr_q[RS1_LSB +: ADDR_W];
    assign rf_A2_o        = instr_q[RS2_LSB +: ADDR_W];
    assign rf_A3_o        = instr_q[RD_LSB +: ADDR_W];
    assign alu_opcode_o   = instr_q[1:0];
    assign result_o       = result_q;

    assign instr_ready_o  = state_q[0];
    assign rf_we_o        = state_q[2];
    assign result_valid_o = state_q[3];
    assign busy_o         = ~state_q[0];

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Testbench for rf_alu_sequencer: closes the loop through a behavioural RF/ALU and
// compares against a whole-instruction reference model.
module tb_rf_alu_sequencer;

    localparam int INSTR_W = 26;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [INSTR_W-1:0] instr_i;
    logic               instr_valid_i;
    logic               instr_ready_o;
    logic [4:0]         rf_A1_o, rf_A2_o, rf_A3_o;
    logic               rf_we_o;
    logic [1:0]         alu_opcode_o;
    logic [31:0]        aluResult;
    logic [31:0]        result_o;
    logic               result_valid_o;
    logic               result_ready_i;
    logic               busy_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rf_alu_sequencer dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .instr_i        (instr_i),
        .instr_valid_i  (instr_valid_i),
        .instr_ready_o  (instr_ready_o),
        .rf_A1_o        (rf_A1_o),
        .rf_A2_o        (rf_A2_o),
        .rf_A3_o        (rf_A3_o),
        .rf_we_o        (rf_we_o),
        .alu_opcode_o   (alu_opcode_o),
        .alu_result_i   (aluResult),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .busy_o         (busy_o)
    );

    function automatic logic [31:0] aluRef(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    function automatic logic [INSTR_W-1:0] encode(input logic [1:0] op, input int rd, input int rs1,
                                                  input int rs2, input bit wb, input int cnt);
        return {cnt[7:0], wb, rs2[4:0], rs1[4:0], rd[4:0], op};
    endfunction

    // Environment register file and combinational ALU.
    logic [31:0] rf [32];
    logic [31:0] expRf [32];
    logic        loadEn;
    logic [4:0]  loadAddr;
    logic [31:0] loadVal;

    assign aluResult = aluRef(alu_opcode_o, rf[rf_A1_o], rf[rf_A2_o]);

    always @(posedge clk) begin
        if (loadEn) rf[loadAddr] <= loadVal;
        else if (rf_we_o) rf[rf_A3_o] <= aluResult;
    end

    typedef struct {
        logic [1:0]  op;
        int          rd, rs1, rs2;
        bit          wb;
        int          cnt;
        int          p1a; logic [31:0] p1v;
        int          p2a; logic [31:0] p2v;
        int          p3a; logic [31:0] p3v;
        logic [31:0] expRes;
        int          expLat;
        int          expWe;
        logic [31:0] expRd;
    } vec_t;

    vec_t vecs [7];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input int a, input logic [31:0] v);
        @(negedge clk);
        loadEn = 1'b1; loadAddr = a[4:0]; loadVal = v;
        @(posedge clk); #1;
        loadEn = 1'b0;
    endtask

    task automatic applyStimulus(input logic [INSTR_W-1:0] ins, output int lat, output int weCnt,
                                 output logic [31:0] res, output bit stable);
        int guard = 0;
        while (!instr_ready_o && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        @(negedge clk);
        instr_i = ins; instr_valid_i = 1'b1;
        @(posedge clk); #1;
        instr_valid_i = 1'b0;
        lat = 1; weCnt = 0; stable = 1'b1;
        while (!result_valid_o && lat < 2000) begin
            if (rf_we_o) weCnt++;
            if (rf_A1_o != ins[11:7] || rf_A2_o != ins[16:12] || rf_A3_o != ins[6:2] ||
                alu_opcode_o != ins[1:0]) stable = 1'b0;
            @(posedge clk); #1; lat++;
        end
        res = result_o;
    endtask

    task automatic finishResult();
        @(negedge clk);
        result_ready_i = 1'b1;
        @(posedge clk); #1;
        result_ready_i = 1'b0;
        checkOutput("readyAfterHandshake", 32'(instr_ready_o), 32'd1);
    endtask

    // Whole-instruction model: run the op cnt+1 times on a copy of the RF.
    task automatic modelRun(input logic [1:0] op, input int rd, input int rs1, input int rs2,
                            input bit wb, input int cnt,
                            output logic [31:0] res, output int lat, output int we);
        expRf = rf;
        if (!wb) begin
            res = aluRef(op, expRf[rs1], expRf[rs2]);
            lat = 2; we = 0;
        end else begin
            res = '0;
            for (int k = 0; k <= cnt; k++) begin
                res = aluRef(op, expRf[rs1], expRf[rs2]);
                expRf[rd] = res;
            end
            lat = 2 * (cnt + 1) + 1; we = cnt + 1;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat, weCnt, mLat, mWe, bad, guard;
        logic [31:0] res, mRes;
        bit          stable, sawValid;
        logic [INSTR_W-1:0] ins;

        vecs[0] = '{2'd0,  3,  1,  2, 1'b1,   0,  1, 32'd5,  2, 32'd7,  3, 32'd0,
                    32'd12, 3, 1, 32'd12};
        vecs[1] = '{2'd0,  1,  1,  2, 1'b1,   3,  1, 32'd5,  2, 32'd7,  1, 32'd5,
                    32'd33, 9, 4, 32'd33};
        vecs[2] = '{2'd2,  6,  4,  5, 1'b0,   9,  4, 32'd3,  5, 32'd4,  6, 32'hDEAD,
                    32'h30, 2, 0, 32'hDEAD};
        vecs[3] = '{2'd1,  7,  8,  9, 1'b1,   1,  8, 32'd100, 9, 32'd30, 7, 32'd0,
                    32'd70, 5, 2, 32'd70};
        vecs[4] = '{2'd3, 10, 10, 11, 1'b1,   2, 10, 32'h80000000, 11, 32'd4, 10, 32'h80000000,
                    32'h00080000, 7, 3, 32'h00080000};
        vecs[5] = '{2'd1, 12, 12, 13, 1'b1,   1, 12, 32'd3, 13, 32'd5, 12, 32'd3,
                    32'hFFFFFFF9, 5, 2, 32'hFFFFFFF9};
        vecs[6] = '{2'd0,  1,  1,  2, 1'b1, 255,  1, 32'd0,  2, 32'd1,  1, 32'd0,
                    32'd256, 513, 256, 32'd256};

        rst_n = 1'b0; instr_i = '0; instr_valid_i = 1'b0; result_ready_i = 1'b0;
        loadEn = 1'b0; loadAddr = '0; loadVal = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstReady",  32'(instr_ready_o),  32'd1);
        checkOutput("rstBusy",   32'(busy_o),         32'd0);
        checkOutput("rstWe",     32'(rf_we_o),        32'd0);
        checkOutput("rstValid",  32'(result_valid_o), 32'd0);
        checkOutput("rstAddr",   32'({rf_A1_o, rf_A2_o, rf_A3_o, alu_opcode_o}), 32'd0);
        checkOutput("rstResult", result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] table-driven vectors");
        for (int v = 0; v < 7; v++) begin
            preload(vecs[v].p1a, vecs[v].p1v);
            preload(vecs[v].p2a, vecs[v].p2v);
            preload(vecs[v].p3a, vecs[v].p3v);
            ins = encode(vecs[v].op, vecs[v].rd, vecs[v].rs1, vecs[v].rs2, vecs[v].wb, vecs[v].cnt);
            applyStimulus(ins, lat, weCnt, res, stable);
            checkOutput($sformatf("vec%0d.result", v), res, vecs[v].expRes);
            checkOutput($sformatf("vec%0d.latency", v), 32'(lat), 32'(vecs[v].expLat));
            checkOutput($sformatf("vec%0d.writes", v), 32'(weCnt), 32'(vecs[v].expWe));
            checkOutput($sformatf("vec%0d.addrStable", v), 32'(stable), 32'd1);
            finishResult();
            checkOutput($sformatf("vec%0d.rdValue", v), rf[vecs[v].rd], vecs[v].expRd);
        end

        $display("[TB] backpressure and simultaneous handshake");
        preload(20, 32'h100); preload(21, 32'h23); preload(22, 32'd9); preload(23, 32'd2);
        applyStimulus(encode(2'd0, 24, 20, 21, 1'b0, 0), lat, weCnt, res, stable);
        checkOutput("bpFirstResult", res, 32'h123);
        @(negedge clk);
        instr_i = encode(2'd1, 25, 22, 23, 1'b0, 0);
        instr_valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checkOutput("bpValidHeld",  32'(result_valid_o), 32'd1);
            checkOutput("bpResultHeld", result_o, 32'h123);
            checkOutput("bpReadyLow",   32'(instr_ready_o), 32'd0);
        end
        @(negedge clk);
        result_ready_i = 1'b1;
        @(posedge clk); #1;
        result_ready_i = 1'b0;
        checkOutput("bpNoBypassIdle", 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        instr_valid_i = 1'b0;
        checkOutput("bpAcceptNext", 32'(busy_o), 32'd1);
        checkOutput("bpNextRs1", 32'(rf_A1_o), 32'd22);
        guard = 0;
        while (!result_valid_o && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        checkOutput("bpSecondResult", result_o, 32'd7);
        finishResult();

        $display("[TB] reset during second write");
        preload(1, 32'd5); preload(2, 32'd7);
        @(negedge clk);
        instr_i = encode(2'd0, 1, 1, 2, 1'b1, 3); instr_valid_i = 1'b1;
        @(posedge clk); #1;
        instr_valid_i = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("rstMidWeBefore", 32'(rf_we_o), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rstMidWe",    32'(rf_we_o),        32'd0);
        checkOutput("rstMidBusy",  32'(busy_o),         32'd0);
        checkOutput("rstMidReady", 32'(instr_ready_o),  32'd1);
        checkOutput("rstMidValid", 32'(result_valid_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rstMidR1", rf[1], 32'd12);
        sawValid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (result_valid_o || busy_o) sawValid = 1'b1;
        end
        checkOutput("rstMidNoResult", 32'(sawValid), 32'd0);

        $display("[TB] randomized instructions against model");
        for (int t = 0; t < 25; t++) begin
            logic [1:0] op;
            int rd, rs1, rs2, cnt;
            bit wb;
            for (int r = 0; r < 32; r++) preload(r, $urandom);
            op  = 2'($urandom_range(0, 3));
            rd  = $urandom_range(0, 31);
            rs1 = $urandom_range(0, 31);
            rs2 = $urandom_range(0, 31);
            wb  = 1'($urandom_range(0, 1));
            cnt = $urandom_range(0, 6);
            modelRun(op, rd, rs1, rs2, wb, cnt, mRes, mLat, mWe);
            applyStimulus(encode(op, rd, rs1, rs2, wb, cnt), lat, weCnt, res, stable);
            checkOutput($sformatf("rnd%0d.result", t), res, mRes);
            checkOutput($sformatf("rnd%0d.latency", t), 32'(lat), 32'(mLat));
            checkOutput($sformatf("rnd%0d.writes", t), 32'(weCnt), 32'(mWe));
            finishResult();
            bad = 0;
            for (int r = 0; r < 32; r++) if (rf[r] !== expRf[r]) bad++;
            checkOutput($sformatf("rnd%0d.rfMismatchCount", t), 32'(bad), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
